hs_src_feeder: RTL and testbench

Source-side feeder for the two-flop handshake synchronizer, on the sclk domain. Buffers incoming words in a small FIFO and launches them one at a time into the synchronizer's source port (sready/din), pacing on its sidle status. Sits directly upstream of the synchronizer and absorbs bursts that arrive faster than one cross-domain round trip per word.

---
 rtl/hs_src_feeder.sv | 103 ++++++++++
 tb/tb_hs_src_feeder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_src_feeder.sv
// hs_src_feeder: sclk-domain feeder for the two-flop handshake synchronizer.
// Buffers producer words in a small circular FIFO and launches them one at a
// time on sready/din, pacing on the synchronizer's sidle status.
module hs_src_feeder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     sidle,
  output logic                     sready,
  output logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [15:0]              sent_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {L_IDLE, L_WAIT} lstate_t;

  lstate_t        state_q, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           push;
  logic           launch;

  assign full       = (count == CW'(DEPTH));
  assign in_ready   = !full;
  assign fifo_count = count;
  assign push       = in_valid && !full;

  // Launch decision: only from idle, only when the synchronizer is idle and
  // the FIFO held a word before this edge (no fall-through of a same-cycle push).
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      L_IDLE: begin
        if (sidle && (count != '0)) begin
          launch  = 1'b1;
          state_d = L_WAIT;
        end
      end
      L_WAIT: begin
        if (!sidle) state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  // Launch FSM state register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= L_IDLE;
    else        state_q <= state_d;
  end

  // FIFO storage; contents are don't-care after reset since count is cleared.
  always_ff @(posedge sclk) begin
    if (push) mem[wptr] <= in_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (launch) rptr <= rptr + AW'(1);
      unique case ({push, launch})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  // Registered launch strobe, held launch data and launch counter.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sready   <= 1'b0;
      din      <= '0;
      sent_cnt <= '0;
    end else begin
      sready <= launch;
      if (launch) begin
        din      <= mem[rptr];
        sent_cnt <= sent_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hs_src_feeder.sv
// tb_hs_src_feeder: scoreboard bench for hs_src_feeder with a simple
// synchronizer sidle model (falls one cycle after sready, high again ~10 later).
module tb_hs_src_feeder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             sclk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sidle;
  logic             sready;
  logic [WIDTH-1:0] din;
  logic [2:0]       fifo_count;
  logic             overflow;
  logic [15:0]      sent_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [15:0]      exp_sent;
  int unsigned      total_pushed;

  logic       sidle_mode;   // 0: model, 1: forced
  logic       sidle_force;
  logic [3:0] busy;
  logic       prev_sready;
  logic       saw_low;

  hs_src_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .sidle      (sidle),
    .sready     (sready),
    .din        (din),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .sent_cnt   (sent_cnt)
  );

  always #5 sclk = ~sclk;

  // Synchronizer source-side model: busy for 10 cycles after sampling sready.
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n)         busy <= '0;
    else if (busy != 0) busy <= busy - 4'd1;
    else if (sready)    busy <= 4'd10;
  end

  assign sidle = sidle_mode ? sidle_force : (busy == 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: each launch pops the scoreboard and checks data, count and pacing.
  always @(negedge sclk) begin
    if (!rst_n) begin
      prev_sready = 1'b0;
      saw_low     = 1'b1;
    end else begin
      if (sready) begin
        check("launch_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("din", 32'(din), 32'(exp_q.pop_front()));
        exp_sent = exp_sent + 16'd1;
        check("sent_cnt", 32'(sent_cnt), 32'(exp_sent));
        check("sready_width", 32'(prev_sready), 32'd0);
        check("sidle_gap", 32'(saw_low), 32'd1);
        saw_low = 1'b0;
      end else if (!sidle) begin
        saw_low = 1'b1;
      end
      prev_sready = sready;
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    exp_sent     = '0;
    total_pushed = 0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // Offer one word for one cycle; scoreboard it only if it will be accepted.
  task automatic offer(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    if (in_ready) begin
      exp_q.push_back(d);
      total_pushed++;
    end
    @(negedge sclk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0 || !sidle) && n < budget) begin
      @(negedge sclk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 8'h5A;
    sidle_mode  = 1'b1;
    sidle_force = 1'b1;
    exp_sent    = '0;
    total_pushed = 0;
    cyc(3);
    check("rst_sready", 32'(sready), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sent", 32'(sent_cnt), 32'd0);

    // First push after release launches 0x5A.
    rst_n = 1'b1;
    exp_q.push_back(8'h5A);
    @(negedge sclk);
    in_valid = 1'b0;
    cyc(3);
    check("first_sent", 32'(sent_cnt), 32'd1);
    check("first_sready_low", 32'(sready), 32'd0);
    check("first_din_held", 32'(din), 32'h5A);
    sidle_force = 1'b0;
    cyc(2);
    sidle_mode = 1'b0;

    // Single word through the sidle model.
    do_reset();
    offer(8'h3C);
    wait_drain(100);
    check("single_sent", 32'(sent_cnt), 32'd1);
    check("single_count", 32'(fifo_count), 32'd0);
    check("single_din_held", 32'(din), 32'h3C);

    // Burst fills the FIFO while the synchronizer is busy, then overflow.
    do_reset();
    sidle_mode  = 1'b1;
    sidle_force = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      if (in_ready) begin
        exp_q.push_back(8'(i));
        total_pushed++;
      end
      @(negedge sclk);
    end
    in_valid = 1'b0;
    check("burst_in_ready", 32'(in_ready), 32'd0);
    check("burst_count", 32'(fifo_count), 32'd4);
    offer(8'hEE);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd4);
    sidle_mode = 1'b0;
    wait_drain(200);
    check("burst_sent", 32'(sent_cnt), 32'd4);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push and pop keeps count at 2.
    do_reset();
    sidle_mode  = 1'b1;
    sidle_force = 1'b0;
    offer(8'h11);
    offer(8'h22);
    check("sim_pre_count", 32'(fifo_count), 32'd2);
    sidle_force = 1'b1;
    offer(8'h77);
    check("sim_sready", 32'(sready), 32'd1);
    check("sim_count", 32'(fifo_count), 32'd2);
    sidle_mode = 1'b0;
    wait_drain(200);
    check("sim_sent", 32'(sent_cnt), 32'd3);

    // Mixed traffic to wrap the pointers several times.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) != 0 && in_ready) offer(8'($urandom_range(0, 255)));
      else @(negedge sclk);
    end
    wait_drain(600);
    check("mixed_sent", 32'(sent_cnt), total_pushed);
    check("mixed_overflow", 32'(overflow), 32'd0);

    // Reset while in L_WAIT with three words queued.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      exp_q.push_back(in_data);
      @(negedge sclk);
    end
    in_valid = 1'b0;
    check("mid_count", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_sready", 32'(sready), 32'd0);
    check("mid_rst_din", 32'(din), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sent", 32'(sent_cnt), 32'd0);
    exp_sent = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(30);
    check("mid_no_stale", 32'(sent_cnt), 32'd0);

    // sent_cnt wraps from 0xFFFF to 0.
    force dut.sent_cnt = 16'hFFFF;
    #1;
    release dut.sent_cnt;
    exp_sent = 16'hFFFF;
    @(negedge sclk);
    offer(8'h99);
    wait_drain(100);
    check("wrap_sent", 32'(sent_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
